alu_unit: RTL

Integer execution unit directly downstream of the ALU reservation station. Accepts one issued operation per cycle on the `ex_*` bus, computes the ALU result or branch outcome, and queues results in a DEPTH-entry in-order output FIFO. Each result is held until the CDB arbiter grants it; the CDB then broadcasts it to the ROB and all reservation stations. The unit throttles the station through `fu_ready`.

---
 rtl/alu_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_unit.sv
// alu_unit: integer execute unit feeding an in-order result FIFO that drains onto the CDB.
// Optional `ALU_MUL_EN` adds a 3-cycle MUL/MULH/MULHSU/MULHU unit.
module alu_unit #(
  parameter int DEPTH        = 4,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    fu_ready,
  input  logic                    ex_valid,
  input  logic [5:0]              ex_op,
  input  logic [31:0]             ex_vj,
  input  logic [31:0]             ex_vk,
  input  logic [31:0]             ex_imm,
  input  logic [31:0]             ex_pc,
  input  logic [31:0]             ex_pred_target,
  input  logic [ROB_ID_WIDTH-1:0] ex_dest,
  output logic                    cdb_req,
  input  logic                    cdb_grant,
  output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]             cdb_value,
  output logic                    cdb_is_branch,
  output logic                    cdb_taken,
  output logic [31:0]             cdb_target,
  output logic                    cdb_mispredict
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_SLL = 6'd3, OP_SLT = 6'd4, OP_SLTU = 6'd5;
  localparam logic [5:0] OP_XOR = 6'd6, OP_SRL = 6'd7, OP_SRA = 6'd8, OP_OR = 6'd9, OP_AND = 6'd10;
  localparam logic [5:0] OP_ADDI = 6'd17, OP_SLLI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22;
  localparam logic [5:0] OP_SRLI = 6'd23, OP_SRAI = 6'd24, OP_ORI = 6'd25, OP_ANDI = 6'd26;
  localparam logic [5:0] OP_LUI = 6'd32, OP_AUIPC = 6'd33, OP_JAL = 6'd34, OP_JALR = 6'd35;
  localparam logic [5:0] OP_BEQ = 6'd40, OP_BNE = 6'd41, OP_BLT = 6'd44, OP_BGE = 6'd45, OP_BLTU = 6'd46, OP_BGEU = 6'd47;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] id;
    logic [31:0]             val;
    logic                    br;
    logic                    tk;
    logic [31:0]             tgt;
    logic                    mp;
  } entry_t;

  logic          w_clr, w_full, w_empty, w_push, w_pop, w_mul_busy, w_mul_op, w_wb;
  logic          w_use_imm, w_br, w_tk;
  logic [31:0]   w_b, w_res, w_jt, w_pc4;
  logic [AW:0]   r_wr, r_rd, w_cnt;
  entry_t        w_alu_e, w_in, w_head;
  entry_t        r_mem [DEPTH];

  assign w_clr     = rst || flush;
  assign w_use_imm = (ex_op[5:4] == 2'b01) || ex_op == OP_LUI || ex_op == OP_AUIPC || ex_op == OP_JALR;
  assign w_b       = w_use_imm ? ex_imm : ex_vk;
  assign w_pc4     = ex_pc + 32'd4;

  always_comb begin
    w_res = '0;
    w_br  = 1'b0;
    w_tk  = 1'b0;
    w_jt  = ex_pc + ex_imm;
    case (ex_op)
      OP_ADD, OP_ADDI:   w_res = ex_vj + w_b;
      OP_SUB:            w_res = ex_vj - w_b;
      OP_SLL, OP_SLLI:   w_res = ex_vj << w_b[4:0];
      OP_SLT, OP_SLTI:   w_res = {31'd0, $signed(ex_vj) < $signed(w_b)};
      OP_SLTU, OP_SLTIU: w_res = {31'd0, ex_vj < w_b};
      OP_XOR, OP_XORI:   w_res = ex_vj ^ w_b;
      OP_SRL, OP_SRLI:   w_res = ex_vj >> w_b[4:0];
      OP_SRA, OP_SRAI:   w_res = $signed(ex_vj) >>> w_b[4:0];
      OP_OR, OP_ORI:     w_res = ex_vj | w_b;
      OP_AND, OP_ANDI:   w_res = ex_vj & w_b;
      OP_LUI:            w_res = w_b;
      OP_AUIPC:          w_res = ex_pc + w_b;
      OP_JAL:            begin w_res = w_pc4; w_br = 1'b1; w_tk = 1'b1; end
      OP_JALR:           begin w_res = w_pc4; w_br = 1'b1; w_tk = 1'b1; w_jt = (ex_vj + ex_imm) & ~32'd1; end
      OP_BEQ:            begin w_br = 1'b1; w_tk = ex_vj == ex_vk; end
      OP_BNE:            begin w_br = 1'b1; w_tk = ex_vj != ex_vk; end
      OP_BLT:            begin w_br = 1'b1; w_tk = $signed(ex_vj) < $signed(ex_vk); end
      OP_BGE:            begin w_br = 1'b1; w_tk = $signed(ex_vj) >= $signed(ex_vk); end
      OP_BLTU:           begin w_br = 1'b1; w_tk = ex_vj < ex_vk; end
      OP_BGEU:           begin w_br = 1'b1; w_tk = ex_vj >= ex_vk; end
      default:           ;
    endcase
  end

  always_comb begin
    w_alu_e     = '0;
    w_alu_e.id  = ex_dest;
    w_alu_e.val = w_res;
    w_alu_e.br  = w_br;
    w_alu_e.tk  = w_tk;
    w_alu_e.tgt = w_tk ? w_jt : w_pc4;
    w_alu_e.mp  = w_br && (w_alu_e.tgt != ex_pred_target);
  end

`ifdef ALU_MUL_EN
  localparam logic [5:0] OP_MUL = 6'd48, OP_MULH = 6'd49, OP_MULHSU = 6'd50, OP_MULHU = 6'd51;
  typedef enum logic [1:0] {S_IDLE, S_M1, S_M2, S_WB} state_t;
  state_t                  r_state, w_nstate;
  logic [32:0]             r_a, r_b;
  logic [63:0]             r_prod;
  logic [31:0]             r_mres;
  logic [5:0]              r_mop;
  logic [ROB_ID_WIDTH-1:0] r_mid;
  entry_t                  w_mul_e;

  assign w_mul_op   = ex_op == OP_MUL || ex_op == OP_MULH || ex_op == OP_MULHSU || ex_op == OP_MULHU;
  assign w_mul_busy = r_state != S_IDLE;
  assign w_wb       = r_state == S_WB;

  always_ff @(posedge clk) r_state <= w_clr ? S_IDLE : w_nstate;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  w_nstate = (ex_valid && w_mul_op && !w_full) ? S_M1 : S_IDLE;
      S_M1:    w_nstate = S_M2;
      S_M2:    w_nstate = S_WB;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Operands are re-latched every idle cycle; the last idle cycle is the accepting one.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_a   <= {ex_op != OP_MULHU && ex_vj[31], ex_vj};
      r_b   <= {(ex_op == OP_MUL || ex_op == OP_MULH) && ex_vk[31], ex_vk};
      r_mop <= ex_op;
      r_mid <= ex_dest;
    end
    if (r_state == S_M1) r_prod <= {{31{r_a[32]}}, r_a} * {{31{r_b[32]}}, r_b};
    if (r_state == S_M2) r_mres <= r_mop == OP_MUL ? r_prod[31:0] : r_prod[63:32];
  end

  always_comb begin
    w_mul_e     = '0;
    w_mul_e.id  = r_mid;
    w_mul_e.val = r_mres;
  end

  assign w_in = w_wb ? w_mul_e : w_alu_e;
`else
  assign w_mul_op   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_wb       = 1'b0;
  assign w_in       = w_alu_e;
`endif

  assign w_cnt    = r_wr - r_rd;
  assign w_empty  = r_wr == r_rd;
  assign w_full   = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign w_push   = !w_clr && !w_full && (w_wb || (ex_valid && !w_mul_op));
  assign w_pop    = !w_clr && cdb_grant && !w_empty;
  // One free slot is held back for the op the station may already have issued.
  assign fu_ready = (w_cnt <= (AW+1)'(DEPTH - 2)) && !w_mul_busy;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) if (w_push) r_mem[r_wr[AW-1:0]] <= w_in;

  assign cdb_req        = !w_empty;
  assign w_head         = cdb_req ? r_mem[r_rd[AW-1:0]] : '0;
  assign cdb_rob_id     = w_head.id;
  assign cdb_value      = w_head.val;
  assign cdb_is_branch  = w_head.br;
  assign cdb_taken      = w_head.tk;
  assign cdb_target     = w_head.tgt;
  assign cdb_mispredict = w_head.mp;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (w_clr) ex_valid |-> !w_full);
endmodule
